// File: rtl/scan_pkg.sv
// Shared types and limits for the scan chain driver and its shift-register datapath.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int CHAIN_LEN_MIN = 2;
  localparam int CHAIN_LEN_MAX = 256;

endpackage

// File: rtl/scan_chain_driver_if.sv
// Pattern/response handshake plus chain-side pins of the scan chain driver.
interface scan_chain_driver_if
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16
);

  // Both handshakes transfer on a clk edge where valid and ready are high together;
  // valid and its payload are held stable until that edge, and ready never depends on valid.
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_data;
  logic                 pat_nocap;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [CHAIN_LEN-1:0] rsp_data;

  logic                 se;
  logic                 si;
  logic                 so;
  logic                 busy;
  state_t               state;

  modport master (
    output pat_valid, pat_data, pat_nocap, rsp_ready, so,
    input  pat_ready, rsp_valid, rsp_data, se, si, busy, state
  );

  modport slave (
    input  pat_valid, pat_data, pat_nocap, rsp_ready, so,
    output pat_ready, rsp_valid, rsp_data, se, si, busy, state
  );

endinterface

// File: rtl/scan_piso_sipo.sv
// Paired pattern (parallel-in/serial-out) and response (serial-in/parallel-out) registers with shift counter.
module scan_piso_sipo #(
  parameter int CHAIN_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rn,
  input  logic                 load,
  input  logic                 shift,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 so,
  output logic                 next_bit,
  output logic [CHAIN_LEN-1:0] rsp_word,
  output logic                 last
);

  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] rsp_sr;
  logic [CNT_W-1:0]     cnt;

  // Bit 0 goes straight to SI at the accept edge, so the register keeps only the remaining bits.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      pat_sr <= '0;
      rsp_sr <= '0;
      cnt    <= '0;
    end else if (load) begin
      pat_sr <= load_data >> 1;
      cnt    <= '0;
    end else if (shift) begin
      pat_sr <= pat_sr >> 1;
      rsp_sr <= rsp_word;
      cnt    <= cnt + 1'b1;
    end
  end

  // Tail bits enter at the top and walk down, so the first unloaded bit ends up in bit 0.
  assign rsp_word = {so, rsp_sr[CHAIN_LEN-1:1]};
  assign next_bit = pat_sr[0];
  assign last     = (cnt == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_driver.sv
// Loads a parallel pattern into a scan chain, pulses one capture edge and returns the previous capture's unload.
module scan_chain_driver
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input logic          clk,
  input logic          rn,
  scan_chain_driver_if.slave bus
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  if (CHAIN_LEN < CHAIN_LEN_MIN || CHAIN_LEN > CHAIN_LEN_MAX) begin : g_len_check
    $error("scan_chain_driver: CHAIN_LEN out of range");
  end

  state_t               state;
  logic                 se_q;
  logic                 si_q;
  logic                 nocap_q;
  logic                 has_cap;
  logic                 rsp_valid_q;
  logic [CHAIN_LEN-1:0] rsp_data_q;

  logic                 load;
  logic                 shift;
  logic                 next_bit;
  logic                 last;
  logic [CHAIN_LEN-1:0] rsp_word;

  assign bus.pat_ready = (state == IDLE) && !rsp_valid_q;
  assign load          = bus.pat_valid && bus.pat_ready;
  assign shift         = (state == SHIFT);

  scan_piso_sipo #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_piso_sipo (
    .clk       (clk),
    .rn        (rn),
    .load      (load),
    .shift     (shift),
    .load_data (bus.pat_data),
    .so        (bus.so),
    .next_bit  (next_bit),
    .rsp_word  (rsp_word),
    .last      (last)
  );

  // has_cap marks that the chain currently holds a captured response worth returning.
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state       <= IDLE;
      se_q        <= 1'b0;
      si_q        <= 1'b0;
      nocap_q     <= 1'b0;
      has_cap     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (load) begin
            nocap_q <= bus.pat_nocap;
            se_q    <= 1'b1;
            si_q    <= bus.pat_data[0];
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last) begin
            se_q <= 1'b0;
            si_q <= 1'b0;
            if (has_cap) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rsp_word;
            end
            if (nocap_q) begin
              has_cap <= 1'b0;
              state   <= IDLE;
            end else begin
              state <= CAPTURE;
            end
          end else begin
            si_q <= next_bit;
          end
        end
        CAPTURE: begin
          has_cap <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.se        = se_q;
  assign bus.si        = si_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver: modelled 8-flop and 2-flop scan chains driven by directed patterns.
module tb_scan_chain_driver;
  import scan_pkg::*;

  localparam int N8 = 8;
  localparam int N2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  scan_chain_driver_if #(.CHAIN_LEN(N8)) b8 ();
  scan_chain_driver_if #(.CHAIN_LEN(N2)) b2 ();

  scan_chain_driver #(.CHAIN_LEN(N8)) u_dut8 (.clk(clk), .rn(rn), .bus(b8));
  scan_chain_driver #(.CHAIN_LEN(N2)) u_dut2 (.clk(clk), .rn(rn), .bus(b2));

  // ---------------- scan chain models ----------------
  // chainX[i] is the flop that pattern bit i lands in; bit 0 is the tail.
  logic [7:0] chain8 = 8'h00;
  logic       d_mode = 1'b0;  // 0: D = 8'h3C, 1: D tied to Q
  assign b8.so = chain8[0];
  always @(posedge clk)
    chain8 <= b8.se ? {b8.si, chain8[7:1]} : (d_mode ? chain8 : 8'h3C);

  logic [1:0] chain2 = 2'b00;
  assign b2.so = chain2[0];
  always @(posedge clk)
    chain2 <= b2.se ? {b2.si, chain2[1]} : 2'b10;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model of the 8-flop driver ----------------
  // m_t: cycles since the pattern was accepted, -1 when idle.
  int         m_t     = -1;
  logic [7:0] m_pat   = 8'h00;
  logic       m_nocap = 1'b0;
  logic       m_hascap = 1'b0;
  logic       m_rv    = 1'b0;
  logic [7:0] m_rsp   = 8'h00;
  logic [7:0] m_snap  = 8'h00;
  logic       m_acc;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      m_t      = -1;
      m_hascap = 1'b0;
      m_rv     = 1'b0;
      m_rsp    = 8'h00;
      exp_q.delete();
    end else begin
      m_acc = b8.pat_valid && (m_t < 0) && !m_rv;
      if (m_rv && b8.rsp_ready) m_rv = 1'b0;
      if (m_t >= 0) begin
        m_t++;
        if (m_t == N8) begin
          if (m_hascap) begin
            m_rv  = 1'b1;
            m_rsp = m_snap;
            exp_q.push_back(m_snap);
          end
          if (m_nocap) begin
            m_hascap = 1'b0;
            m_t      = -1;
          end
        end else if (m_t == N8 + 1) begin
          m_hascap = 1'b1;
          m_t      = -1;
        end
      end else if (m_acc) begin
        m_t     = 0;
        m_pat   = b8.pat_data;
        m_nocap = b8.pat_nocap;
      end
    end
  end

  // Cycle-by-cycle compare; the chain seen right after the accept edge is what gets unloaded.
  always @(negedge clk) begin
    if (m_t == 0) m_snap = chain8;
    check("se",        32'(b8.se),        32'(m_t >= 0 && m_t < N8));
    check("si",        32'(b8.si),        32'((m_t >= 0 && m_t < N8) ? m_pat[m_t] : 1'b0));
    check("busy",      32'(b8.busy),      32'(m_t >= 0));
    check("pat_ready", 32'(b8.pat_ready), 32'(m_t < 0 && !m_rv));
    check("rsp_valid", 32'(b8.rsp_valid), 32'(m_rv));
    check("rsp_data",  32'(b8.rsp_data),  32'(m_rsp));
  end

  // ---------------- run-length / response monitors ----------------
  int         se_len = 0, busy_len = 0;
  int         se_runs[$];
  int         busy_runs[$];
  int         rsp_rises = 0, rsp2_rises = 0;
  logic       rv_prev = 1'b0, rv2_prev = 1'b0;
  logic [7:0] last_rsp = 8'h00;
  logic [1:0] last_rsp2 = 2'b00;

  always @(negedge clk) begin
    if (b8.se) se_len++;
    else if (se_len > 0) begin se_runs.push_back(se_len); se_len = 0; end
    if (b8.busy) busy_len++;
    else if (busy_len > 0) begin busy_runs.push_back(busy_len); busy_len = 0; end
    if (b8.rsp_valid && !rv_prev) begin
      rsp_rises++;
      last_rsp = b8.rsp_data;
      if (exp_q.size() > 0) check("rsp_word", 32'(b8.rsp_data), 32'(exp_q.pop_front()));
    end
    rv_prev = b8.rsp_valid;
    if (b2.rsp_valid && !rv2_prev) begin rsp2_rises++; last_rsp2 = b2.rsp_data; end
    rv2_prev = b2.rsp_valid;
  end

  // ---------------- drivers ----------------
  int acc8_cyc = 0;
  int acc2_cyc = 0;

  task automatic send8(input logic [7:0] d, input logic nc);
    bit ok = 1'b0;
    @(negedge clk);
    b8.pat_valid = 1'b1; b8.pat_data = d; b8.pat_nocap = nc;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (b8.pat_ready) begin
        @(posedge clk); #1;
        ok = 1'b1; acc8_cyc = cyc; b8.pat_valid = 1'b0;
      end else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; b8.pat_valid = 1'b0;
      $display("FAIL send8: pattern %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic send2(input logic [1:0] d, input logic nc);
    bit ok = 1'b0;
    @(negedge clk);
    b2.pat_valid = 1'b1; b2.pat_data = d; b2.pat_nocap = nc;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (b2.pat_ready) begin
        @(posedge clk); #1;
        ok = 1'b1; acc2_cyc = cyc; b2.pat_valid = 1'b0;
      end else @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; b2.pat_valid = 1'b0;
      $display("FAIL send2: pattern %0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic wait_idle8();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!b8.busy && b8.pat_ready) ok = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wait_idle8: driver not idle within 100 cycles"); end
  endtask

  task automatic wait_idle2();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!b2.busy && b2.pat_ready) ok = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wait_idle2: driver not idle within 100 cycles"); end
  endtask

  task automatic clear_mon();
    se_runs.delete(); busy_runs.delete(); rsp_rises = 0;
  endtask

  // ---------------- directed sequence ----------------
  int rel_cyc;

  initial begin
    b8.pat_valid = 1'b0; b8.pat_data = '0; b8.pat_nocap = 1'b0; b8.rsp_ready = 1'b1;
    b2.pat_valid = 1'b0; b2.pat_data = '0; b2.pat_nocap = 1'b0; b2.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_se",    32'(b8.se), 0);
    check("reset_state", 32'(b8.state), 32'(IDLE));
    check("reset_rdata", 32'(b8.rsp_data), 0);
    rn = 1'b1;

    // Fixed D = 8'h3C: first captured pattern returns nothing, the NOCAP unload returns 3C.
    d_mode = 1'b0; clear_mon();
    send8(8'hA5, 1'b0);
    send8(8'h00, 1'b1);
    wait_idle8();
    check("a_rsp_rises", 32'(rsp_rises), 1);
    check("a_rsp_data",  32'(last_rsp), 32'h3C);
    check("a_runs",      32'(busy_runs.size()), 2);
    if (busy_runs.size() == 2) begin
      check("a_busy_cap",   32'(busy_runs[0]), 9);
      check("a_busy_nocap", 32'(busy_runs[1]), 8);
      check("a_se_cap",     32'(se_runs[0]), 8);
      check("a_se_nocap",   32'(se_runs[1]), 8);
    end

    // Loopback chain: captured pattern comes straight back.
    d_mode = 1'b1; clear_mon();
    send8(8'hA5, 1'b0);
    send8(8'h5A, 1'b1);
    wait_idle8();
    check("b_rsp_rises", 32'(rsp_rises), 1);
    check("b_rsp_data",  32'(last_rsp), 32'hA5);
    if (se_runs.size() == 2) begin
      check("b_se_first",  32'(se_runs[0]), 8);
      check("b_se_second", 32'(se_runs[1]), 8);
    end else check("b_se_runs", 32'(se_runs.size()), 2);

    // Backpressure on the response blocks the next pattern.
    clear_mon(); b8.rsp_ready = 1'b0;
    send8(8'h11, 1'b0);
    send8(8'h22, 1'b0);
    fork
      send8(8'h33, 1'b0);
      begin
        repeat (20) @(negedge clk);
        check("hold_ready", 32'(b8.pat_ready), 0);
        check("hold_se",    32'(b8.se), 0);
        check("hold_valid", 32'(b8.rsp_valid), 1);
        check("hold_rdata", 32'(b8.rsp_data), 32'h11);
        rel_cyc = cyc;
        b8.rsp_ready = 1'b1;
      end
    join
    check("hold_resume", 32'(acc8_cyc - rel_cyc), 2);
    send8(8'h44, 1'b1);
    wait_idle8();
    check("hold_rises", 32'(rsp_rises), 3);
    check("hold_last",  32'(last_rsp), 32'h33);

    // Asynchronous reset in the middle of a shift.
    send8(8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #2 rn = 1'b0;
    #1;
    check("rst_se",     32'(b8.se), 0);
    check("rst_si",     32'(b8.si), 0);
    check("rst_busy",   32'(b8.busy), 0);
    check("rst_rvalid", 32'(b8.rsp_valid), 0);
    @(negedge clk); rn = 1'b1;
    clear_mon();
    send8(8'h66, 1'b0);
    wait_idle8();
    check("rst_no_rsp", 32'(rsp_rises), 0);
    send8(8'h77, 1'b1);
    wait_idle8();
    check("rst_rises", 32'(rsp_rises), 1);
    check("rst_last",  32'(last_rsp), 32'h66);

    // Two-flop chain, back-to-back captured patterns.
    send2(2'b01, 1'b0);
    rel_cyc = acc2_cyc;
    send2(2'b10, 1'b0);
    check("n2_period", 32'(acc2_cyc - rel_cyc), 4);
    wait_idle2();
    check("n2_rises", 32'(rsp2_rises), 1);
    check("n2_rdata", 32'(last_rsp2), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
